// File: rtl/mdu_param.sv
// Multiply/divide unit that owns HI/LO for the E stage. The result is computed
// when the operation is launched, then held back until the configured latency has elapsed.
module mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] hi_reg, hi_next, lo_reg, lo_next;
    logic [WIDTH-1:0] pend_hi_reg, pend_hi_next, pend_lo_reg, pend_lo_next;

    logic               is_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, acc, mac;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [CW-1:0]      latency;

    // Even opcodes are signed, odd ones unsigned, across all three groups.
    assign is_signed = ~op[0];

    // Sign/zero extension to 2*WIDTH keeps the truncated product correct modulo 2^(2*WIDTH).
    assign a_ext = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign b_ext = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign prod  = a_ext * b_ext;
    assign acc   = {hi_reg, lo_reg};
    assign mac   = op[1] ? (acc - prod) : (acc + prod);

    // Magnitude division; MIN / -1 falls out as MIN with remainder 0.
    assign a_neg  = is_signed & a[WIDTH-1];
    assign b_neg  = is_signed & b[WIDTH-1];
    assign a_mag  = a_neg ? (~a + ONE) : a;
    assign b_mag  = b_neg ? (~b + ONE) : b;
    assign b_safe = (b == '0) ? ONE : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quo    = (a_neg ^ b_neg) ? (~q_mag + ONE) : q_mag;
    assign rem    = a_neg ? (~r_mag + ONE) : r_mag;

    assign latency = (op[2:1] == 2'b01) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    always_comb begin
        res_hi = hi_reg;
        res_lo = lo_reg;
        case (op)
            3'd0, 3'd1: {res_hi, res_lo} = prod;
            3'd2, 3'd3: begin
                if (b != '0) begin
                    res_hi = rem;
                    res_lo = quo;
                end
            end
            default:    {res_hi, res_lo} = mac;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    pend_hi_next = res_hi;
                    pend_lo_next = res_lo;
                    count_next   = latency;
                    state_next   = RUN;
                end else begin
                    if (wr_hi) hi_next = wdata;
                    if (wr_lo) lo_next = wdata;
                end
            end
            RUN: begin
                if (count_reg == CW'(1)) begin
                    hi_next    = pend_hi_reg;
                    lo_next    = pend_lo_reg;
                    count_next = '0;
                    state_next = IDLE;
                end else begin
                    count_next = count_reg - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign hi   = hi_reg;
    assign lo   = lo_reg;
endmodule

// File: tb/tb_mdu_param.sv
// Directed bench for mdu_param: a 32-bit 5/10-cycle instance and a 16-bit 1/1-cycle instance
// share one stimulus bus; each test looks only at the instance it targets.
module tb_mdu_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b, wdata;
    logic        wr_hi, wr_lo;

    logic        busy32, busy16;
    logic [31:0] hi32, lo32;
    logic [15:0] hi16, lo16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy32), .hi(hi32), .lo(lo32)
    );

    mdu_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a[15:0]), .b(b[15:0]),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata[15:0]),
        .busy(busy16), .hi(hi16), .lo(lo16)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        int          cycles;
    } vec_t;

    vec_t v32[12];
    vec_t v16[5];

    function automatic logic get_busy(int sel);
        return (sel == 0) ? busy32 : busy16;
    endfunction
    function automatic logic [31:0] get_hi(int sel);
        return (sel == 0) ? hi32 : {16'h0, hi16};
    endfunction
    function automatic logic [31:0] get_lo(int sel);
        return (sel == 0) ? lo32 : {16'h0, lo16};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        wr_hi = 1'b1; wdata = h; tick();
        wr_hi = 1'b0; wr_lo = 1'b1; wdata = l; tick();
        wr_lo = 1'b0;
    endtask

    // Returns in the first busy cycle.
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
    endtask

    // Counts busy cycles from now; returns in the first cycle busy reads 0.
    task automatic wait_idle(input int sel, output int n);
        n = 0;
        while (get_busy(sel) && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic run_vec(input int sel, input int idx, input vec_t v);
        int n;
        preload(v.pre_hi, v.pre_lo);
        launch(v.op, v.a, v.b);
        wait_idle(sel, n);
        $display("w%0d vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d",
                 (sel == 0) ? 32 : 16, idx, v.op, v.a, v.b, get_hi(sel), get_lo(sel), n);
        check($sformatf("w%0d_vec%0d_cycles", (sel == 0) ? 32 : 16, idx), 32'(n), 32'(v.cycles));
        check($sformatf("w%0d_vec%0d_hi", (sel == 0) ? 32 : 16, idx), get_hi(sel), v.exp_hi);
        check($sformatf("w%0d_vec%0d_lo", (sel == 0) ? 32 : 16, idx), get_lo(sel), v.exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //            op     a             b             pre_hi        pre_lo        exp_hi        exp_lo        cyc
        v32[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        v32[1]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD, 10};
        v32[2]  = '{3'd3, 32'd7,        32'd0,        32'hAA,       32'h55,       32'hAA,       32'h55,       10};
        v32[3]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h0,        32'h0,        32'h1,        32'hFFFFFFFE, 5};
        v32[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h80000000, 10};
        v32[5]  = '{3'd4, 32'hFFFFFFFE, 32'd3,        32'h0,        32'd16,       32'h0,        32'd10,       5};
        v32[6]  = '{3'd7, 32'd1,        32'd1,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5};
        v32[7]  = '{3'd3, 32'hFFFFFFFF, 32'h10,       32'h0,        32'h0,        32'hF,        32'h0FFFFFFF, 10};
        v32[8]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        v32[9]  = '{3'd0, 32'h10000,    32'h10000,    32'h0,        32'h0,        32'h1,        32'h0,        5};
        v32[10] = '{3'd5, 32'd1,        32'd1,        32'h0,        32'hFFFFFFFF, 32'h1,        32'h0,        5};
        v32[11] = '{3'd6, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        32'h0,        32'h1,        5};

        v16[0]  = '{3'd6, 32'd3,        32'd3,        32'h0,        32'h0,        32'hFFFF,     32'hFFF7,     1};
        v16[1]  = '{3'd0, 32'hFFFD,     32'd5,        32'h0,        32'h0,        32'hFFFF,     32'hFFF1,     1};
        v16[2]  = '{3'd2, 32'd7,        32'hFFFE,     32'h0,        32'h0,        32'h0001,     32'hFFFD,     1};
        v16[3]  = '{3'd3, 32'd7,        32'd0,        32'hAA,       32'h55,       32'hAA,       32'h55,       1};
        v16[4]  = '{3'd2, 32'h8000,     32'hFFFF,     32'h0,        32'h0,        32'h0,        32'h8000,     1};

        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        tick(); tick();
        check("reset_busy32", 32'(busy32), 32'd0);
        check("reset_hi32", hi32, 32'h0);
        check("reset_lo32", lo32, 32'h0);
        check("reset_busy16", 32'(busy16), 32'd0);
        check("reset_hi16", {16'h0, hi16}, 32'h0);
        check("reset_lo16", {16'h0, lo16}, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) run_vec(0, i, v32[i]);

        // Back-to-back: MADDU launched in the cycle busy falls; carry ripples from lo into hi.
        preload(32'h0, 32'h0);
        launch(3'd1, 32'hFFFFFFFF, 32'd2);
        wait_idle(0, n);
        check("b2b_multu_cycles", 32'(n), 32'd5);
        check("b2b_multu_hi", hi32, 32'h1);
        check("b2b_multu_lo", lo32, 32'hFFFFFFFE);
        launch(3'd5, 32'd1, 32'd2);
        wait_idle(0, n);
        $display("w32 b2b maddu -> hi=%h lo=%h busy_cycles=%0d", hi32, lo32, n);
        check("b2b_maddu_cycles", 32'(n), 32'd5);
        check("b2b_maddu_hi", hi32, 32'h2);
        check("b2b_maddu_lo", lo32, 32'h0);

        // start pulsed mid-division is ignored.
        launch(3'd2, 32'h80000000, 32'hFFFFFFFF);
        tick(); tick();
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
        tick();
        start = 1'b0;
        wait_idle(0, n);
        $display("w32 div with stray start -> hi=%h lo=%h busy_cycles=%0d", hi32, lo32, n + 3);
        check("stray_start_cycles", 32'(n + 3), 32'd10);
        check("stray_start_hi", hi32, 32'h0);
        check("stray_start_lo", lo32, 32'h80000000);

        // start and wr_hi together: start wins; wr_lo during busy is ignored.
        preload(32'h5, 32'h6);
        wr_hi = 1'b1; wdata = 32'h77;
        launch(3'd3, 32'd9, 32'd0);
        wr_hi = 1'b0;
        check("start_wins_busy", 32'(busy32), 32'd1);
        check("start_wins_hi", hi32, 32'h5);
        wr_lo = 1'b1; wdata = 32'h99;
        tick();
        wr_lo = 1'b0;
        check("wr_while_busy_lo", lo32, 32'h6);
        wait_idle(0, n);
        $display("w32 divu/0 with writes -> hi=%h lo=%h busy_cycles=%0d", hi32, lo32, n + 1);
        check("wr_while_busy_cycles", 32'(n + 1), 32'd10);
        check("wr_while_busy_hi_end", hi32, 32'h5);
        check("wr_while_busy_lo_end", lo32, 32'h6);

        // Simultaneous MTHI/MTLO both take wdata without raising busy.
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h3C;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
        check("wr_both_hi", hi32, 32'h3C);
        check("wr_both_lo", lo32, 32'h3C);
        check("wr_both_busy", 32'(busy32), 32'd0);

        // Reset in busy cycle 3 aborts the multiply; nothing commits afterwards.
        preload(32'h11, 32'h22);
        launch(3'd0, 32'd4, 32'd4);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy32), 32'd0);
        check("abort_hi", hi32, 32'h0);
        check("abort_lo", lo32, 32'h0);
        repeat (8) tick();
        $display("w32 aborted mult -> hi=%h lo=%h busy=%0d", hi32, lo32, busy32);
        check("abort_after_busy", 32'(busy32), 32'd0);
        check("abort_after_hi", hi32, 32'h0);
        check("abort_after_lo", lo32, 32'h0);

        for (int i = 0; i < 5; i++) run_vec(1, i, v16[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
